// File: rtl/dma_controller.sv
// rtl/dma_controller.sv - block-transfer bus master moving words between memory and I/O regions
// Two clocks per word (READ then WRITE); all outputs registered.
module dma_controller #(
  parameter logic [7:0] MEM_TOP  = 8'd191,
  parameter logic [7:0] IO1_BASE = 8'd192,
  parameter logic [7:0] IO2_BASE = 8'd224
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        grant,
  input  logic [7:0]  D_source,
  input  logic [7:0]  D_destination,
  input  logic [5:0]  D_count,
  inout  wire  [31:0] databus,
  output logic [7:0]  D_address,
  output logic        D_IOWrite1,
  output logic        D_IOWrite2,
  output logic        D_memwrite,
  output logic        busybus,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, FINISH} state_t;

  state_t      state;
  logic [7:0]  src;
  logic [7:0]  dst;
  logic [5:0]  remaining;
  logic [31:0] hold;
  logic        drive;

  assign databus = drive ? hold : 32'bz;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      src        <= 8'h00;
      dst        <= 8'h00;
      remaining  <= 6'd0;
      hold       <= 32'h0;
      drive      <= 1'b0;
      D_address  <= 8'h00;
      D_IOWrite1 <= 1'b0;
      D_IOWrite2 <= 1'b0;
      D_memwrite <= 1'b0;
      busybus    <= 1'b0;
      done       <= 1'b0;
    end else begin
      // Strobes, bus drive and done are single-cycle unless re-asserted below
      D_IOWrite1 <= 1'b0;
      D_IOWrite2 <= 1'b0;
      D_memwrite <= 1'b0;
      drive      <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          D_address <= 8'h00;
          busybus   <= 1'b0;
          if (grant) begin
            if (D_count != 6'd0) begin
              src       <= D_source;
              dst       <= D_destination;
              remaining <= D_count;
              D_address <= D_source;
              busybus   <= 1'b1;
              state     <= READ;
            end else begin
              done  <= 1'b1;
              state <= FINISH;
            end
          end
        end
        READ: begin
          hold       <= databus;
          D_address  <= dst;
          drive      <= 1'b1;
          D_memwrite <= (dst <= MEM_TOP);
          D_IOWrite1 <= (dst >= IO1_BASE) && (dst < IO2_BASE);
          D_IOWrite2 <= (dst >= IO2_BASE);
          state      <= WRITE;
        end
        WRITE: begin
          src       <= src + 8'd1;
          dst       <= dst + 8'd1;
          remaining <= remaining - 6'd1;
          if (remaining == 6'd1) begin
            D_address <= 8'h00;
            busybus   <= 1'b0;
            done      <= 1'b1;
            state     <= FINISH;
          end else if (grant) begin
            D_address <= src + 8'd1;
            state     <= READ;
          end else begin
            // Grant lost at a word boundary: abandon the rest without done
            D_address <= 8'h00;
            busybus   <= 1'b0;
            state     <= IDLE;
          end
        end
        FINISH: begin
          D_address <= 8'h00;
          busybus   <= 1'b0;
          if (!grant) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_controller.sv
// tb/tb_dma_controller.sv - directed self-checking bench for dma_controller
module tb_dma_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        grant = 1'b0;
  logic [7:0]  D_source = 8'h00;
  logic [7:0]  D_destination = 8'h00;
  logic [5:0]  D_count = 6'd0;
  wire  [31:0] databus;
  logic [7:0]  D_address;
  logic        D_IOWrite1, D_IOWrite2, D_memwrite, busybus, done;

  logic [31:0] mem [0:255];
  logic        tb_drv;
  logic [7:0]  l_addr [0:15];
  logic [2:0]  l_str  [0:15];
  logic        l_busy [0:15];
  logic        l_done [0:15];
  int          ln;
  int          vectors = 0;
  int          miscompares = 0;

  dma_controller dut (
    .clock(clock), .reset(reset), .grant(grant),
    .D_source(D_source), .D_destination(D_destination), .D_count(D_count),
    .databus(databus), .D_address(D_address),
    .D_IOWrite1(D_IOWrite1), .D_IOWrite2(D_IOWrite2), .D_memwrite(D_memwrite),
    .busybus(busybus), .done(done)
  );

  always #5 clock = ~clock;

  // Bus targets answer whenever the master owns the bus without a write strobe
  assign tb_drv  = busybus && !(D_memwrite || D_IOWrite1 || D_IOWrite2);
  assign databus = tb_drv ? mem[D_address] : 32'bz;

  function automatic logic [31:0] pat(input logic [7:0] a);
    return {8'hC3, a, 8'h5A, ~a};
  endfunction

  task automatic cap(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      l_addr[ln] = D_address;
      l_str[ln]  = {D_IOWrite2, D_IOWrite1, D_memwrite};
      l_busy[ln] = busybus;
      l_done[ln] = done;
      if (|l_str[ln]) mem[D_address] = databus;
      ln++;
    end
  endtask

  task automatic start(input logic [7:0] s, input logic [7:0] d, input logic [5:0] c);
    D_source = s; D_destination = d; D_count = c; grant = 1'b1; ln = 0;
  endtask

  task automatic release_grant();
    grant = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset();
    #12;
    vectors++;
    if ({D_address, D_IOWrite1, D_IOWrite2, D_memwrite, busybus, done} !== 13'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected 0", {D_address, D_IOWrite1, D_IOWrite2, D_memwrite, busybus, done});
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    vectors++;
    if ({D_address, busybus, done} !== 10'h0) begin
      miscompares++;
      $display("FAIL idle_outputs: got %h expected 0", {D_address, busybus, done});
    end
  endtask

  task automatic test_mem_to_mem();
    logic [31:0] abc [0:2];
    abc[0] = 32'hAAAA_0001; abc[1] = 32'hBBBB_0002; abc[2] = 32'hCCCC_0003;
    for (int k = 0; k < 3; k++) mem[20 + k] = abc[k];
    start(8'd20, 8'd100, 6'd3);
    cap(8);
    for (int k = 0; k < 8; k++) begin
      logic [7:0] ea;
      logic [2:0] es;
      ea = (k >= 6) ? 8'd0 : (k % 2 == 0) ? 8'(20 + k / 2) : 8'(100 + k / 2);
      es = (k < 6 && k % 2 == 1) ? 3'b001 : 3'b000;
      vectors++;
      if (l_addr[k] !== ea || l_str[k] !== es || l_busy[k] !== (k < 6) || l_done[k] !== (k == 6)) begin
        miscompares++;
        $display("FAIL m2m_cycle%0d: got addr=%0d str=%b busy=%b done=%b expected addr=%0d str=%b busy=%b done=%b",
                 k, l_addr[k], l_str[k], l_busy[k], l_done[k], ea, es, k < 6, k == 6);
      end
    end
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (mem[100 + k] !== abc[k]) begin
        miscompares++;
        $display("FAIL m2m_data%0d: got %h expected %h", k, mem[100 + k], abc[k]);
      end
    end
    release_grant();
  endtask

  task automatic test_mem_io();
    start(8'd5, 8'd192, 6'd2);
    cap(4);
    vectors++;
    if (l_addr[1] !== 8'd192 || l_str[1] !== 3'b010 || l_addr[3] !== 8'd193 || l_str[3] !== 3'b010 ||
        l_addr[2] !== 8'd6 || l_str[2] !== 3'b000) begin
      miscompares++;
      $display("FAIL m2io1: got %0d/%b %0d/%0b %0d/%b expected 192/010 6/000 193/010",
               l_addr[1], l_str[1], l_addr[2], l_str[2], l_addr[3], l_str[3]);
    end
    vectors++;
    if (mem[193] !== pat(8'd6)) begin
      miscompares++;
      $display("FAIL m2io1_data: got %h expected %h", mem[193], pat(8'd6));
    end
    release_grant();
    start(8'd224, 8'd50, 6'd2);
    cap(4);
    vectors++;
    if (l_addr[1] !== 8'd50 || l_str[1] !== 3'b001 || l_addr[3] !== 8'd51 || l_str[3] !== 3'b001) begin
      miscompares++;
      $display("FAIL io2m: got %0d/%b %0d/%b expected 50/001 51/001", l_addr[1], l_str[1], l_addr[3], l_str[3]);
    end
    vectors++;
    if (mem[50] !== pat(8'd224) || mem[51] !== pat(8'd225)) begin
      miscompares++;
      $display("FAIL io2m_data: got %h %h expected %h %h", mem[50], mem[51], pat(8'd224), pat(8'd225));
    end
    release_grant();
  endtask

  task automatic test_region_wrap();
    start(8'd30, 8'd222, 6'd3);
    cap(6);
    vectors++;
    if (l_str[1] !== 3'b010 || l_str[3] !== 3'b010 || l_str[5] !== 3'b100 ||
        l_addr[1] !== 8'd222 || l_addr[3] !== 8'd223 || l_addr[5] !== 8'd224) begin
      miscompares++;
      $display("FAIL region_cross: got %0d/%b %0d/%b %0d/%b expected 222/010 223/010 224/100",
               l_addr[1], l_str[1], l_addr[3], l_str[3], l_addr[5], l_str[5]);
    end
    release_grant();
    start(8'd255, 8'd150, 6'd2);
    cap(4);
    vectors++;
    if (l_addr[0] !== 8'd255 || l_addr[2] !== 8'd0) begin
      miscompares++;
      $display("FAIL src_wrap: got %0d %0d expected 255 0", l_addr[0], l_addr[2]);
    end
    vectors++;
    if (mem[151] !== pat(8'd0)) begin
      miscompares++;
      $display("FAIL wrap_data: got %h expected %h", mem[151], pat(8'd0));
    end
    release_grant();
  endtask

  task automatic test_grant_drop();
    start(8'd0, 8'd64, 6'd5);
    cap(3);
    grant = 1'b0;
    cap(3);
    vectors++;
    if (l_addr[3] !== 8'd65 || l_str[3] !== 3'b001 || l_busy[3] !== 1'b1) begin
      miscompares++;
      $display("FAIL drop_last_write: got addr=%0d str=%b busy=%b expected 65 001 1", l_addr[3], l_str[3], l_busy[3]);
    end
    vectors++;
    if (l_busy[4] !== 1'b0 || l_done[4] !== 1'b0 || l_done[5] !== 1'b0 || l_addr[4] !== 8'd0 || l_busy[5] !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_idle: got busy=%b done=%b%b addr=%0d expected busy=0 done=00 addr=0",
               l_busy[4], l_done[4], l_done[5], l_addr[4]);
    end
    vectors++;
    if (mem[65] !== pat(8'd1)) begin
      miscompares++;
      $display("FAIL drop_data: got %h expected %h", mem[65], pat(8'd1));
    end
  endtask

  task automatic test_zero_count();
    int dones;
    int busy_cycles;
    start(8'd7, 8'd8, 6'd0);
    cap(4);
    dones = 0; busy_cycles = 0;
    for (int k = 0; k < 4; k++) begin
      dones += int'(l_done[k]);
      busy_cycles += int'(l_busy[k] || (|l_str[k]));
    end
    vectors++;
    if (dones != 1 || l_done[0] !== 1'b1 || busy_cycles != 0) begin
      miscompares++;
      $display("FAIL zero_count: got dones=%0d first=%b bus_cycles=%0d expected 1 1 0", dones, l_done[0], busy_cycles);
    end
    release_grant();
  endtask

  task automatic test_reset_mid_block();
    start(8'd10, 8'd200, 6'd4);
    cap(4);
    vectors++;
    if (l_addr[3] !== 8'd201 || l_str[3] !== 3'b010) begin
      miscompares++;
      $display("FAIL mid_second_write: got %0d/%b expected 201/010", l_addr[3], l_str[3]);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if ({D_address, D_IOWrite1, D_IOWrite2, D_memwrite, busybus, done} !== 13'h0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: got %h expected 0", {D_address, D_IOWrite1, D_IOWrite2, D_memwrite, busybus, done});
    end
    D_source = 8'd40; D_destination = 8'd60; D_count = 6'd1;
    @(negedge clock);
    reset = 1'b0;
    ln = 0;
    cap(3);
    vectors++;
    if (l_addr[0] !== 8'd40 || l_addr[1] !== 8'd60 || l_str[1] !== 3'b001 || l_done[2] !== 1'b1 || l_busy[2] !== 1'b0) begin
      miscompares++;
      $display("FAIL restart: got %0d %0d/%b done=%b busy=%b expected 40 60/001 done=1 busy=0",
               l_addr[0], l_addr[1], l_str[1], l_done[2], l_busy[2]);
    end
    vectors++;
    if (mem[60] !== pat(8'd40)) begin
      miscompares++;
      $display("FAIL restart_data: got %h expected %h", mem[60], pat(8'd40));
    end
    release_grant();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = pat(8'(i));
    ln = 0;
    test_reset();
    test_mem_to_mem();
    test_mem_io();
    test_region_wrap();
    test_grant_drop();
    test_zero_count();
    test_reset_mid_block();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
